// File: rtl/config_pkg.sv
// Shared types and constants for the UART transmit controller.
// Build option UART_TX_PARITY_EN inserts an even-parity slot between the data bits and the stop bit.
package config_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned DATA_W               = 8;
    localparam int unsigned BIT_IDX_W            = 3;

    typedef logic [DATA_W-1:0] tx_byte_t;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// TX FIFO read port: the FIFO (master) presents its head byte, the controller (slave) pops it.
interface uart_tx_ctrl_if;
    import config_pkg::*;

    logic     fifo_have_next;
    tx_byte_t fifo_data;
    logic     fifo_next;

    modport master (output fifo_have_next, output fifo_data, input fifo_next);
    modport slave  (input fifo_have_next, input fifo_data, output fifo_next);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick_c is high on the last clock of each bit; clr_i restarts the period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = config_pkg::CLKS_PER_BIT_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops bytes from a TX FIFO and sends 8N1 frames LSB first.
// Define UART_TX_PARITY_EN to send an even-parity bit before the stop bit.
module uart_tx_ctrl
    import config_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           tx_en_i,
    uart_tx_ctrl_if.slave  fifo,
    output logic           tx_o,
    output logic           busy_o
);

    tx_state_e              state_q, state_d;
    tx_byte_t               shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   baud_tick_c;
    logic                   baud_clr_c;
    logic                   pop_c;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (baud_clr_c),
        .tick_c  (baud_tick_c)
    );

    // Pop is gated by reset so the FIFO is never drained while the block is held in reset.
    assign pop_c          = reset_i && (state_q == IDLE) && tx_en_i && fifo.fifo_have_next;
    assign fifo.fifo_next = pop_c;
    assign tx_o           = tx_q;
    assign busy_o         = busy_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pop_c) begin
                    shift_d   = fifo.fifo_data;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^fifo.fifo_data;
`endif
                    state_d   = START;
                end
            end
            START: begin
                if (baud_tick_c) state_d = DATA;
            end
            DATA: begin
                if (baud_tick_c) begin
                    shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick_c) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_tick_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line level and busy are registered from the next state so they align with state_q.
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d     = (state_d != IDLE);
        baud_clr_c = (state_d != state_q);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl at CLKS_PER_BIT=4; stimulus queues expected bytes, a line monitor decodes frames.
// Define UART_TX_PARITY_EN to exercise the parity build.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FRAME = SLOTS * CPB;

    logic clk_i = 1'b0;
    logic reset_i;
    logic tx_en_i;
    logic tx_o;
    logic busy_o;

    uart_tx_ctrl_if fifo_if ();

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tx_en_i (tx_en_i),
        .fifo    (fifo_if),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         pop_cyc[$];
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       prev_pop = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fifo_refresh();
        fifo_if.fifo_have_next = (fifo_q.size() != 0);
        fifo_if.fifo_data      = (fifo_q.size() != 0) ? fifo_q[0] : 8'hA5;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_on_line);
        fifo_q.push_back(b);
        if (expect_on_line) exp_q.push_back(b);
        fifo_refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        for (int i = 0; i < budget && pop_cnt < target; i++) tick(1);
        check(pop_cnt >= target, name, pop_cnt, target);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy_o !== 1'b0) && i < budget) begin
            i++;
            tick(1);
        end
        check(exp_q.size() == 0 && busy_o === 1'b0, name, exp_q.size(), 0);
    endtask

    // FIFO model: legality of each pop is checked, head byte is removed just after the consuming edge.
    always @(negedge clk_i) begin
        if (fifo_if.fifo_next === 1'b1) begin
            check({tx_en_i, fifo_if.fifo_have_next, busy_o, prev_pop, reset_i} === 5'b11001, "pop_legal",
                  {27'd0, tx_en_i, fifo_if.fifo_have_next, busy_o, prev_pop, reset_i}, 32'h19);
            pop_cyc.push_back(cyc);
            pop_cnt++;
            prev_pop = 1'b1;
            @(posedge clk_i);
            #1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            fifo_refresh();
        end else begin
            prev_pop = 1'b0;
        end
    end

    // Line monitor: decodes each frame slot by slot and compares against the scoreboard head.
    initial begin : frame_mon
        logic [7:0] got;
        logic [7:0] e;
        logic       slot_v;
        logic       par_v;
        bit         shape_ok;
        bit         busy_ok;
        bit         aborted;
        int         s;
        forever begin
            @(negedge clk_i);
            if (reset_i === 1'b1 && tx_o === 1'b0) begin
                got = '0; par_v = 1'b0; slot_v = 1'b0;
                shape_ok = 1'b1; busy_ok = 1'b1; aborted = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k != 0) @(negedge clk_i);
                    if (reset_i !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (busy_o !== 1'b1) busy_ok = 1'b0;
                    if (k % CPB == 0) slot_v = tx_o;
                    else if (tx_o !== slot_v) shape_ok = 1'b0;
                    if (k % CPB == CPB - 1) begin
                        s = k / CPB;
                        if (s == 0) begin
                            if (slot_v !== 1'b0) shape_ok = 1'b0;
                        end else if (s <= 8) begin
                            got[s-1] = slot_v;
                        end else if (s == SLOTS - 1) begin
                            if (slot_v !== 1'b1) shape_ok = 1'b0;
                        end else begin
                            par_v = slot_v;
                        end
                    end
                end
                if (!aborted) begin
                    @(negedge clk_i);
                    check(tx_o === 1'b1 && busy_o === 1'b0, "frame_gap", {30'd0, tx_o, busy_o}, 32'h2);
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", {24'd0, got}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check(got == e, "frame_byte", {24'd0, got}, {24'd0, e});
                        check(shape_ok, "frame_shape", {31'd0, shape_ok}, 1);
                        check(busy_ok, "frame_busy", {31'd0, busy_ok}, 1);
`ifdef UART_TX_PARITY_EN
                        check(par_v == ^e, "parity_bit", {31'd0, par_v}, {31'd0, ^e});
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int blen;
        int bad;

        reset_i = 1'b0;
        tx_en_i = 1'b1;
        fifo_refresh();
        tick(3);
        check({tx_o, busy_o, fifo_if.fifo_next} === 3'b100, "reset_state",
              {29'd0, tx_o, busy_o, fifo_if.fifo_next}, 32'h4);
        tick(2);
        reset_i = 1'b1;

        // Enabled with an empty FIFO: line idles, nothing is popped.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if ({tx_o, busy_o, fifo_if.fifo_next} !== 3'b100) bad++;
        end
        check(bad == 0, "idle_empty_50", bad, 0);

        // Single byte 0x13.
        base = pop_cnt;
        push_byte(8'h13, 1'b1);
        wait_pops(base + 1, 10, "pop_0x13");
        blen = 0;
        while (busy_o === 1'b1 && blen < 200) begin
            blen++;
            tick(1);
        end
        check(blen == FRAME, "busy_len", blen, FRAME);
        tick(5);
        check(pop_cnt == base + 1, "single_pop", pop_cnt, base + 1);

        // Back-to-back bytes.
        base = pop_cnt;
        push_byte(8'h37, 1'b1);
        push_byte(8'hDE, 1'b1);
        push_byte(8'hAD, 1'b1);
        wait_pops(base + 3, 3 * (FRAME + 1) + 10, "pop_burst");
        if (pop_cyc.size() >= base + 3) begin
            check(pop_cyc[base+1] - pop_cyc[base] == FRAME + 1, "pop_spacing_1",
                  pop_cyc[base+1] - pop_cyc[base], FRAME + 1);
            check(pop_cyc[base+2] - pop_cyc[base+1] == FRAME + 1, "pop_spacing_2",
                  pop_cyc[base+2] - pop_cyc[base+1], FRAME + 1);
        end
        wait_quiet(200, "burst_done");

        // Enable dropped mid-frame: frame completes, next byte waits for re-enable.
        base = pop_cnt;
        push_byte(8'hAD, 1'b1);
        push_byte(8'h5A, 1'b1);
        wait_pops(base + 1, 10, "pop_en_test");
        tick(9);
        tx_en_i = 1'b0;
        check(busy_o === 1'b1, "busy_at_disable", {31'd0, busy_o}, 1);
        tick(FRAME + 40);
        check(pop_cnt == base + 1, "no_pop_while_disabled", pop_cnt, base + 1);
        check(exp_q.size() == 1, "frame_done_while_disabled", exp_q.size(), 1);
        tx_en_i = 1'b1;
        wait_pops(base + 2, 10, "pop_reenabled");
        wait_quiet(200, "reenable_done");

        // Reset during the data bits of 0xDE: byte discarded, 0x81 follows.
        base = pop_cnt;
        push_byte(8'hDE, 1'b0);
        push_byte(8'h81, 1'b1);
        wait_pops(base + 1, 10, "pop_before_reset");
        tick(5);
        check(tx_o === 1'b0 && busy_o === 1'b1, "pre_reset_data0", {30'd0, tx_o, busy_o}, 32'h1);
        reset_i = 1'b0;
        #1;
        check({tx_o, busy_o, fifo_if.fifo_next} === 3'b100, "reset_mid_frame",
              {29'd0, tx_o, busy_o, fifo_if.fifo_next}, 32'h4);
        tick(2);
        reset_i = 1'b1;
        wait_pops(base + 2, 10, "pop_after_reset");
        wait_quiet(200, "after_reset_done");

        tick(5);
        check(fifo_q.size() == 0, "fifo_drained", fifo_q.size(), 0);
        check(pop_cnt == 8, "total_pops", pop_cnt, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
